// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready front-end for a single-port RW SRAM macro
// with a 1-cycle registered-address read and a byte-masked write.
// Read data is captured one cycle after issue into a small response FIFO,
// so the consumer may apply backpressure without stalling the macro pipe.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. Valid never depends on ready. req_ready depends only on
// internal occupancy, and resp_valid depends only on FIFO occupancy.
module sram_req_adapter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MASK_W     = 4,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RESP_DEPTH);

  logic [CNT_W-1:0]  occ;
  logic              rd_pend;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];

  logic              fire;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    inflight;

  // Reads in flight count against FIFO space so a capture can never overflow.
  assign inflight  = {1'b0, occ} + {{CNT_W{1'b0}}, rd_pend};
  assign req_ready = !reset && (inflight < DEPTH_C);
  assign fire      = req_valid && req_ready;

  // The macro port is a straight pass-through; the mask is meaningless on reads.
  assign sram_en    = fire;
  assign sram_wmode = req_write;
  assign sram_addr  = req_addr;
  assign sram_wdata = req_wdata;
  assign sram_wmask = req_write ? req_wmask : '0;

  // Capture happens in the cycle after a read fires, when the macro output is valid.
  assign push       = rd_pend;
  assign resp_valid = (occ != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_data  = fifo_mem[rd_ptr];

  // Control state: pending-read flag, occupancy and wrapping pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend <= 1'b0;
      occ     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      rd_pend <= fire && !req_write;
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Response storage: data only, no reset needed; a read pending at reset is dropped.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr] <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed testbench for sram_req_adapter with a behavioural SRAM macro
// (registered-address read, byte-masked write) and an in-order response queue.
module tb_sram_req_adapter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  logic              clock;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_count = 0;
  logic [DATA_W-1:0] exp_q[$];

  sram_req_adapter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RESP_DEPTH(3)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural SRAM macro
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MASK_W; l++) begin
          if (sram_wmask[l]) ram[sram_addr][l*8 +: 8] <= sram_wdata[l*8 +: 8];
        end
      end else begin
        sram_rdata <= ram[sram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted response must match the head of the expected queue
  always @(negedge clock) begin
    if (reset === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("stale_resp", {63'b0, resp_valid}, 64'd0);
      end else begin
        check("resp_data", {32'b0, resp_data}, {32'b0, exp_q.pop_front()});
      end
      resp_count++;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [MASK_W-1:0] m);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wmask = '0;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  int base_cnt;

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;
    tick(); tick(); tick();
    // Reset state
    check("rst_req_ready", {63'b0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rst_sram_en", {63'b0, sram_en}, 64'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("post_rst_ready", {63'b0, req_ready}, 64'd1);

    // T1 single read with 2-cycle latency
    do_write(10'd5, 32'hDEADBEEF, 4'hF);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd5; req_wmask = 4'hF;
    #1;
    check("t1_sram_en", {63'b0, sram_en}, 64'd1);
    check("t1_wmask_forced", {60'b0, sram_wmask}, 64'd0);
    check("t1_wmode", {63'b0, sram_wmode}, 64'd0);
    check("t1_addr", {54'b0, sram_addr}, 64'd5);
    tick();
    req_valid = 1'b0;
    check("t1_valid_n1", {63'b0, resp_valid}, 64'd0);
    tick();
    check("t1_valid_n2", {63'b0, resp_valid}, 64'd1);
    check("t1_data", {32'b0, resp_data}, 64'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    resp_ready = 1'b1;
    wait_drain("t1_drain");

    // T2 streaming 16 back-to-back reads
    for (int i = 0; i < 16; i++) do_write(ADDR_W'(16 + i), 32'hA5000000 + 32'(16 + i), 4'hF);
    base_cnt = resp_count;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = ADDR_W'(16 + i);
      exp_q.push_back(32'hA5000000 + 32'(16 + i));
      #1;
      check("t2_ready", {63'b0, req_ready}, 64'd1);
      if (i >= 2) check("t2_valid", {63'b0, resp_valid}, 64'd1);
      tick();
    end
    req_valid = 1'b0;
    check("t2_tail_valid0", {63'b0, resp_valid}, 64'd1);
    tick();
    check("t2_tail_valid1", {63'b0, resp_valid}, 64'd1);
    wait_drain("t2_drain");
    check("t2_count", 64'(resp_count - base_cnt), 64'd16);

    // T3 backpressure: exactly three reads accepted
    for (int i = 0; i < 3; i++) do_write(ADDR_W'(40 + i), 32'hC0DE0000 + 32'(40 + i), 4'hF);
    tick();
    resp_ready = 1'b0;
    base_cnt = resp_count;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = ADDR_W'(40 + ((c < 3) ? c : 3));
      #1;
      check("t3_ready", {63'b0, req_ready}, (c < 3) ? 64'd1 : 64'd0);
      if (c < 3) exp_q.push_back(32'hC0DE0000 + 32'(40 + c));
      tick();
    end
    req_valid = 1'b0;
    check("t3_valid", {63'b0, resp_valid}, 64'd1);
    check("t3_head", {32'b0, resp_data}, 64'hC0DE0028);
    tick();
    check("t3_head_stable", {32'b0, resp_data}, 64'hC0DE0028);
    resp_ready = 1'b1;
    #1;
    check("t3_ready_still0", {63'b0, req_ready}, 64'd0);
    tick();
    check("t3_ready_back", {63'b0, req_ready}, 64'd1);
    wait_drain("t3_drain");
    check("t3_count", 64'(resp_count - base_cnt), 64'd3);
    check("t3_empty", {63'b0, resp_valid}, 64'd0);

    // T4 masked write
    do_write(10'd7, 32'h11223344, 4'hF);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd7;
    req_wdata = 32'hAABBCCDD; req_wmask = 4'b0101;
    #1;
    check("t4_wmode", {63'b0, sram_wmode}, 64'd1);
    check("t4_wmask", {60'b0, sram_wmask}, 64'h5);
    tick();
    do_read(10'd7, 32'h11BB33DD);
    wait_drain("t4_drain");

    // T5 read-then-write same address returns old data, later read returns new
    do_write(10'd9, 32'h1, 4'hF);
    do_read(10'd9, 32'h1);
    do_write(10'd9, 32'h2, 4'hF);
    do_read(10'd9, 32'h2);
    wait_drain("t5_drain");

    // T6 reset mid-flight discards queued and pending reads
    do_write(10'd50, 32'h50505050, 4'hF);
    do_write(10'd51, 32'h51515151, 4'hF);
    do_write(10'd52, 32'h52525252, 4'hF);
    do_write(10'd60, 32'h60606060, 4'hF);
    tick();
    resp_ready = 1'b0;
    do_read(10'd50, 32'h50505050);
    do_read(10'd51, 32'h51515151);
    do_read(10'd52, 32'h52525252);
    check("t6_queued", {63'b0, resp_valid}, 64'd1);
    exp_q.delete();
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd60;
    #1;
    check("t6_rst_ready", {63'b0, req_ready}, 64'd0);
    check("t6_rst_en", {63'b0, sram_en}, 64'd0);
    tick();
    check("t6_rst_valid", {63'b0, resp_valid}, 64'd0);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    check("t6_ready_after", {63'b0, req_ready}, 64'd1);
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_stale", {63'b0, resp_valid}, 64'd0);
    end
    do_read(10'd60, 32'h60606060);
    check("t6_lat_n1", {63'b0, resp_valid}, 64'd0);
    tick();
    check("t6_lat_n2", {63'b0, resp_valid}, 64'd1);
    check("t6_data", {32'b0, resp_data}, 64'h60606060);
    wait_drain("t6_drain");

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
